// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit processor: opcodes, register field codes,
// default bus widths, fetch FSM states and the JMP decode helper.
package cpu16_pkg;

    localparam int CPU_ADDR_W = 8;
    localparam int CPU_DATA_W = 16;

    // Opcodes live in instr[15:12]; 4'hE and 4'hF are unused and fetch as plain words.
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LD  = 4'h1;
    localparam logic [3:0] OP_ST  = 4'h2;
    localparam logic [3:0] OP_MOV = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8;
    localparam logic [3:0] OP_NOT = 4'h9;
    localparam logic [3:0] OP_SHL = 4'hA;
    localparam logic [3:0] OP_SHR = 4'hB;
    localparam logic [3:0] OP_JZ  = 4'hC;
    localparam logic [3:0] OP_JMP = 4'hD;

    // Register field codes used by the execute stage.
    localparam logic [2:0] REG_ACC   = 3'd0;
    localparam logic [2:0] REG_A     = 3'd1;
    localparam logic [2:0] REG_B     = 3'd2;
    localparam logic [2:0] REG_C     = 3'd3;
    localparam logic [2:0] REG_E     = 3'd4;
    localparam logic [2:0] REG_D     = 3'd5;
    localparam logic [2:0] REG_MADDR = 3'd6;
    localparam logic [2:0] REG_ZERO  = 3'd7;

    // Non-prefetch fetch sequencer: issue address, capture ROM word, present it.
    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_CAPT  = 2'd1,
        S_VALID = 2'd2
    } fetch_state_e;

    function automatic logic is_jmp(input logic [CPU_DATA_W-1:0] word);
        return word[15:12] == OP_JMP;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO of {pc, instr} words returned by program_rom. A synchronous
// flush empties it in one cycle and takes priority over push and pop.
module fetch_fifo #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic [1:0]   count
);
    import cpu16_pkg::*;

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_push;
    logic         do_pop;

    // Refuse a push into a full FIFO unless the head leaves in the same cycle.
    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer, occupancy and storage update; reset clears storage so the head reads 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: reads program_rom (registered address, word
// valid the cycle after the ROM registers it) and presents instructions to
// execute over valid/ready. JMP (opcode 4'hD) is resolved here.
// Handshake: instr/instr_pc are meaningful while instr_valid=1 and are held
// stable until the cycle instr_valid&instr_ready is seen at a clock edge,
// which is when execute takes the word.
// Build option: FETCH_PREFETCH_EN selects a pipelined fetch path with a
// 2-entry FIFO; without it a three-state sequencer fetches one word at a time.
module fetch_unit
    import cpu16_pkg::*;
#(
    parameter int               ADDR_W   = CPU_ADDR_W,
    parameter int               DATA_W   = CPU_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] addr_p,
    input  logic [DATA_W-1:0] in_prom,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] instr_pc
);

`ifdef FETCH_PREFETCH_EN

    localparam int FW = ADDR_W + DATA_W;

    // s1_* tracks the single fetch in flight: its address is in the ROM's
    // address register and its word appears on in_prom this cycle.
    logic              s1_v;
    logic [ADDR_W-1:0] s1_pc;
    logic [1:0]        fifo_count;
    logic [FW-1:0]     head;
    logic              pop;
    logic              push;
    logic              jmp_taken;
    logic              issue;

    assign instr_valid = (fifo_count != 2'd0);
    assign instr_pc    = head[FW-1:DATA_W];
    assign instr       = head[DATA_W-1:0];
    assign pop         = instr_valid && instr_ready;
    assign jmp_taken   = pop && is_jmp(instr);
    assign push        = s1_v && !jmp_taken;
    // Credit the slot freed by a same-cycle pop so sequential code streams at one word per cycle.
    assign issue = ({1'b0, fifo_count} + {2'b00, s1_v}) < (3'd2 + {2'b00, pop});

    // Issue pointer and in-flight tracking; an accepted JMP discards everything younger.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_p <= RESET_PC;
            s1_v   <= 1'b0;
            s1_pc  <= '0;
        end else if (jmp_taken) begin
            addr_p <= instr[ADDR_W-1:0];
            s1_v   <= 1'b0;
        end else begin
            s1_v  <= issue;
            s1_pc <= addr_p;
            if (issue) begin
                addr_p <= addr_p + 1'b1;
            end
        end
    end

    fetch_fifo #(.W(FW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (jmp_taken),
        .push  (push),
        .pop   (pop),
        .wdata ({s1_pc, in_prom}),
        .rdata (head),
        .count (fifo_count)
    );

`else

    fetch_state_e      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;

    // Address of the next fetch once the presented word is accepted.
    assign next_pc = is_jmp(instr) ? instr[ADDR_W-1:0] : pc + 1'b1;

    // Fetch sequencer: ROM registers addr_p in S_ISSUE, word captured in S_CAPT, held in S_VALID.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            addr_p      <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            instr_pc    <= '0;
            state       <= S_ISSUE;
        end else begin
            case (state)
                S_ISSUE: begin
                    state <= S_CAPT;
                end
                S_CAPT: begin
                    instr       <= in_prom;
                    instr_pc    <= pc;
                    instr_valid <= 1'b1;
                    state       <= S_VALID;
                end
                S_VALID: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        pc          <= next_pc;
                        addr_p      <= next_pc;
                        state       <= S_ISSUE;
                    end
                end
                default: begin
                    state <= S_ISSUE;
                end
            endcase
        end
    end

`endif

endmodule
